// File: rtl/m_mc_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, FSM states,
// mux select codes, instruction classes and the one-hot immediate format bundle.
package m_mc_ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [3:0] {
    C_NONE,
    C_OP,
    C_OPIMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC
  } cls_e;

  typedef struct packed {
    logic i;
    logic s;
    logic b;
    logic u;
    logic j;
  } fmt_t;

endpackage

// File: rtl/m_mc_ctrl_decode.sv
// m_mc_decode: combinational RV32I opcode classifier for the multi-cycle controller.
// Maps ir to an instruction class, one-hot immediate format and ALU op.
module m_mc_decode
  import m_mc_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_e        cls,
  output fmt_t        fmt,
  output logic [3:0]  alu_op,
  output logic        legal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_ir;

  assign opc       = ir[6:0];
  assign f3        = ir[14:12];
  assign f7b5      = ir[30];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  always_comb begin
    cls    = C_NONE;
    fmt    = '0;
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (opc)
      OP: begin
        cls    = C_OP;
        alu_op = {f7b5, f3};
      end
      OP_IMM: begin
        cls    = C_OPIMM;
        fmt.i  = 1'b1;
        // only SRAI carries funct7[5]; other immediates use that bit as data
        alu_op = {f7b5 & (f3 == 3'b101), f3};
      end
      LOAD: begin
        cls   = C_LOAD;
        fmt.i = 1'b1;
      end
      STORE: begin
        cls   = C_STORE;
        fmt.s = 1'b1;
      end
      BRANCH: begin
        cls    = C_BRANCH;
        fmt.b  = 1'b1;
        alu_op = {1'b0, f3};
      end
      JAL: begin
        cls   = C_JAL;
        fmt.j = 1'b1;
      end
      JALR: begin
        cls   = C_JALR;
        fmt.i = 1'b1;
      end
      LUI: begin
        cls   = C_LUI;
        fmt.u = 1'b1;
      end
      AUIPC: begin
        cls   = C_AUIPC;
        fmt.u = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/m_mc_ctrl.sv
// m_mc_ctrl: multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb) with bus timeout.
// Define MC_CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of retiring them as NOP.
module m_mc_ctrl
  import m_mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        imm_i,
  output logic        imm_s,
  output logic        imm_b,
  output logic        imm_u,
  output logic        imm_j,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        bus_err,
  output logic        trap
);

  localparam logic [WAIT_W-1:0] TMO    = WAIT_W'(MEM_TIMEOUT);
  localparam bit                TMO_EN = (MEM_TIMEOUT != 0);

  logic [2:0]        state_q, state_d;
  logic              run_q, run_d;
  cls_e              cls_q, cls_d;
  fmt_t              fmt_q, fmt_d;
  logic [3:0]        aluop_q, aluop_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              bus_err_q, bus_err_d;
  logic              tmo;

  cls_e       dec_cls;
  fmt_t       dec_fmt;
  logic [3:0] dec_aluop;
  logic       dec_legal;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
`endif

  m_mc_decode u_dec (
    .ir     (ir),
    .cls    (dec_cls),
    .fmt    (dec_fmt),
    .alu_op (dec_aluop),
    .legal  (dec_legal)
  );

  assign wait_inc = wait_q + 1'b1;
  assign tmo      = TMO_EN && (wait_inc == TMO);
  assign bus_err  = bus_err_q;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    {imm_i, imm_s, imm_b, imm_u, imm_j} = '0;

    state_d   = state_q;
    run_d     = 1'b1;
    cls_d     = cls_q;
    fmt_d     = fmt_q;
    aluop_d   = aluop_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    trap_d    = trap_q;
`endif

    case (state_q)
      S_FETCH: begin
        // run_q keeps the request low for the cycle right after reset
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
          end else if (tmo) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            wait_d = wait_inc;
          end
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        fmt_d   = dec_fmt;
        aluop_d = dec_aluop;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          trap_d  = 1'b1;
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else if (cls_q == C_BRANCH) begin
          if (br_taken) begin
            pc_we  = 1'b1;
            pc_sel = PC_IMM;
          end
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ack) begin
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        end else if (tmo) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
        if (cls_q == C_LOAD) begin
          wb_sel = WB_LOAD;
        end else if (cls_q == C_JAL || cls_q == C_JALR) begin
          wb_sel = WB_PC4;
          pc_we  = 1'b1;
          pc_sel = (cls_q == C_JAL) ? PC_IMM : PC_JALR;
        end
      end
      S_HALT, S_TRAP: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      {imm_i, imm_s, imm_b, imm_u, imm_j} = fmt_q;
      alu_a_sel = (cls_q == C_AUIPC) || (cls_q == C_JAL);
      alu_b_sel = (cls_q != C_OP) && (cls_q != C_BRANCH);
      alu_op    = aluop_q;
    end

    if (state_d == S_FETCH && state_q != S_FETCH) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      cls_q     <= C_NONE;
      fmt_q     <= '0;
      aluop_q   <= ALU_ADD;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      cls_q     <= cls_d;
      fmt_q     <= fmt_d;
      aluop_q   <= aluop_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
`endif

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Self-checking bench for m_mc_ctrl: random instruction stream against a cycle
// model built from per-class phase lists, plus reset, illegal and timeout scenarios.
module tb_m_mc_ctrl;

  localparam int P_F  = 0;
  localparam int P_FA = 1;
  localparam int P_D  = 2;
  localparam int P_E  = 3;
  localparam int P_M  = 4;
  localparam int P_MA = 5;
  localparam int P_W  = 6;

  localparam int K_OP    = 0;
  localparam int K_OPIMM = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_BR    = 4;
  localparam int K_JAL   = 5;
  localparam int K_JALR  = 6;
  localparam int K_LUI   = 7;
  localparam int K_AUIPC = 8;
  localparam int K_ILL   = 9;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [4:0] imm;
    logic       alu_a;
    logic       alu_b;
    logic [3:0] alu_op;
    logic       bus_err;
    logic       trap;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic        br_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
  logic [1:0]  pc_sel, wb_sel;
  logic        imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        alu_a_sel, alu_b_sel;
  logic [3:0]  alu_op;
  logic        bus_err, trap;

  int vec = 0;
  int err = 0;

  logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                           7'h6f, 7'h67, 7'h37, 7'h17};

  always #5 clk = ~clk;

  m_mc_ctrl #(.MEM_TIMEOUT(4), .WAIT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ir        (ir),
    .br_taken  (br_taken),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .imm_i     (imm_i),
    .imm_s     (imm_s),
    .imm_b     (imm_b),
    .imm_u     (imm_u),
    .imm_j     (imm_j),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .alu_op    (alu_op),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .bus_err   (bus_err),
    .trap      (trap)
  );

  function automatic ov_t sample();
    ov_t o;
    o.imem_req = imem_req;
    o.ir_we    = ir_we;
    o.pc_we    = pc_we;
    o.pc_sel   = pc_sel;
    o.dmem_req = dmem_req;
    o.dmem_we  = dmem_we;
    o.rf_we    = rf_we;
    o.wb_sel   = wb_sel;
    o.imm      = {imm_i, imm_s, imm_b, imm_u, imm_j};
    o.alu_a    = alu_a_sel;
    o.alu_b    = alu_b_sel;
    o.alu_op   = alu_op;
    o.bus_err  = bus_err;
    o.trap     = trap;
    return o;
  endfunction

  function automatic int cls_of(input logic [6:0] o);
    case (o)
      7'h33:   return K_OP;
      7'h13:   return K_OPIMM;
      7'h03:   return K_LOAD;
      7'h23:   return K_STORE;
      7'h63:   return K_BR;
      7'h6f:   return K_JAL;
      7'h67:   return K_JALR;
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      default: return K_ILL;
    endcase
  endfunction

  // {i,s,b,u,j}
  function automatic logic [4:0] fmt_of(input int k);
    case (k)
      K_OPIMM, K_LOAD, K_JALR: return 5'b10000;
      K_STORE:                 return 5'b01000;
      K_BR:                    return 5'b00100;
      K_LUI, K_AUIPC:          return 5'b00010;
      K_JAL:                   return 5'b00001;
      default:                 return 5'b00000;
    endcase
  endfunction

  task automatic test_reset();
    ov_t obs;
    rst = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    br_taken = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    obs = sample();
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL reset_hold got=%h want=0", obs);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b0;
    #1;
    obs = sample();
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL reset_release got=%h want=0", obs);
    end
  endtask

  task automatic test_instr_stream(input int n);
    logic [31:0] ins;
    int          fd, md, k;
    logic        br;
    int          ph[$];
    ov_t         exp, msk, obs;
    for (int t = 0; t < n + 4; t++) begin
      fd = 0;
      md = 0;
      br = 1'b0;
      case (t)
        0: ins = 32'h00500093;
        1: begin ins = 32'h0020A223; md = 3; end
        2: begin ins = 32'h00000463; br = 1'b1; end
        3: ins = 32'h008000EF;
        default: begin
          ins      = $urandom();
          ins[6:0] = opcs[$urandom_range(0, 8)];
          fd       = $urandom_range(0, 3);
          md       = $urandom_range(0, 3);
          br       = 1'($urandom_range(0, 1));
        end
      endcase
      k = cls_of(ins[6:0]);
      ph.delete();
      for (int c = 0; c < fd; c++) ph.push_back(P_F);
      ph.push_back(P_FA);
      ph.push_back(P_D);
      ph.push_back(P_E);
      if (k == K_LOAD || k == K_STORE) begin
        for (int c = 0; c < md; c++) ph.push_back(P_M);
        ph.push_back(P_MA);
      end
      if (k != K_STORE && k != K_BR) ph.push_back(P_W);
      foreach (ph[p]) begin
        @(negedge clk);
        ir       = ins;
        imem_ack = (ph[p] == P_FA) ? 1'b1 :
                   (ph[p] == P_F)  ? 1'b0 : 1'($urandom_range(0, 1));
        dmem_ack = (ph[p] == P_MA) ? 1'b1 :
                   (ph[p] == P_M)  ? 1'b0 : 1'($urandom_range(0, 1));
        br_taken = (ph[p] == P_E) ? br : 1'($urandom_range(0, 1));
        #1;
        exp = '0;
        msk = '0;
        msk.imem_req = 1'b1;
        msk.ir_we    = 1'b1;
        msk.pc_we    = 1'b1;
        msk.dmem_req = 1'b1;
        msk.rf_we    = 1'b1;
        msk.bus_err  = 1'b1;
        msk.trap     = 1'b1;
        if (ph[p] == P_E || ph[p] == P_M || ph[p] == P_MA || ph[p] == P_W) begin
          msk.imm = 5'h1f;
          exp.imm = fmt_of(k);
        end
        case (ph[p])
          P_F: exp.imem_req = 1'b1;
          P_FA: begin
            exp.imem_req = 1'b1;
            exp.ir_we    = 1'b1;
            exp.pc_we    = 1'b1;
            msk.pc_sel   = 2'b11;
          end
          P_E: begin
            msk.alu_a = (k != K_JAL && k != K_JALR && k != K_LUI);
            exp.alu_a = (k == K_AUIPC);
            msk.alu_b = (k != K_JAL);
            exp.alu_b = !(k == K_OP || k == K_BR);
            if (k == K_OP || k == K_LOAD || k == K_STORE ||
                k == K_LUI || k == K_AUIPC) msk.alu_op = 4'hf;
            if (k == K_OP) exp.alu_op = {ins[30], ins[14:12]};
            if (k == K_BR && br) begin
              exp.pc_we  = 1'b1;
              exp.pc_sel = 2'd1;
              msk.pc_sel = 2'b11;
            end
          end
          P_M, P_MA: begin
            exp.dmem_req = 1'b1;
            exp.dmem_we  = (k == K_STORE);
            msk.dmem_we  = 1'b1;
          end
          P_W: begin
            exp.rf_we  = 1'b1;
            msk.wb_sel = 2'b11;
            exp.wb_sel = (k == K_LOAD) ? 2'd1 :
                         (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
            if (k == K_JAL || k == K_JALR) begin
              exp.pc_we  = 1'b1;
              exp.pc_sel = (k == K_JAL) ? 2'd1 : 2'd2;
              msk.pc_sel = 2'b11;
            end
          end
          default: ;
        endcase
        obs = sample();
        vec++;
        if ((obs & msk) !== (exp & msk)) begin
          err++;
          $display("FAIL stream t=%0d ir=%h phase=%0d got=%h want=%h",
                   t, ins, ph[p], obs & msk, exp & msk);
        end
      end
    end
  endtask

  task automatic test_illegal();
    ov_t obs;
    @(negedge clk);
    ir = 32'h00000000;
    imem_ack = 1'b1;
    #1;
    obs = sample();
    vec++;
    if (obs.ir_we !== 1'b1 || obs.trap !== 1'b0) begin
      err++;
      $display("FAIL illegal_fetch got ir_we=%b trap=%b want 1 0", obs.ir_we, obs.trap);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    obs = sample();
    vec++;
    if (obs.pc_we !== 1'b0 || obs.rf_we !== 1'b0 || obs.imem_req !== 1'b0) begin
      err++;
      $display("FAIL illegal_decode got=%h want strobes 0", obs);
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      #1;
      obs = sample();
      vec++;
      if (obs !== ov_t'(1)) begin
        err++;
        $display("FAIL illegal_trap c=%0d got=%h want=%h", c, obs, ov_t'(1));
      end
    end
    rst = 1'b1;
    #1;
    obs = sample();
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL trap_reset got=%h want=0", obs);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b0;
`else
    @(negedge clk);
    #1;
    obs = sample();
    vec++;
    if (obs.imem_req !== 1'b1 || obs.trap !== 1'b0 || obs.rf_we !== 1'b0) begin
      err++;
      $display("FAIL illegal_nop got req=%b trap=%b rf_we=%b want 1 0 0",
               obs.imem_req, obs.trap, obs.rf_we);
    end
`endif
  endtask

  task automatic test_timeout();
    ov_t obs, exp;
    @(negedge clk);
    ir = 32'h00002083;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      obs = sample();
      vec++;
      if (obs.dmem_req !== 1'b1 || obs.bus_err !== 1'b0) begin
        err++;
        $display("FAIL timeout_wait c=%0d got req=%b err=%b want 1 0",
                 c, obs.dmem_req, obs.bus_err);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      #1;
      obs = sample();
      exp = '0;
      exp.bus_err = 1'b1;
      vec++;
      if (obs !== exp) begin
        err++;
        $display("FAIL timeout_halt c=%0d got=%h want=%h", c, obs, exp);
      end
    end
    rst = 1'b1;
    #1;
    obs = sample();
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL timeout_reset got=%h want=0", obs);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    ov_t obs;
    @(negedge clk);
    ir = 32'h0020A223;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    obs = sample();
    vec++;
    if (obs.dmem_req !== 1'b1 || obs.dmem_we !== 1'b1) begin
      err++;
      $display("FAIL mid_mem_req got req=%b we=%b want 1 1", obs.dmem_req, obs.dmem_we);
    end
    #2;
    rst = 1'b1;
    #1;
    obs = sample();
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL mid_mem_async got=%h want=0", obs);
    end
    @(negedge clk);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    #1;
    obs = sample();
    vec++;
    if (obs !== '0) begin
      err++;
      $display("FAIL mid_mem_held got=%h want=0", obs);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_instr_stream(40);
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
